// File: rtl/pipe_skid_stage_pkg.sv
// Shared defines for the IF->ID skid stage: default widths, the RV32I NOP
// encoding used as the bubble, and the occupancy state encoding.
package pipe_skid_stage_pkg;

  localparam int          DEFAULT_DATA_W = 32;
  localparam int          DEFAULT_ADDR_W = 32;
  localparam logic [31:0] RV32I_NOP      = 32'h0000_0013;

  // The encoding is chosen so that the state value is also the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  function automatic logic [1:0] entry_count(input skid_state_t state);
    return 2'(state);
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between fetch and decode. The main register drives the
// outputs; the skid register absorbs the one entry that arrives while ID stalls.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                DATA_W      = DEFAULT_DATA_W,
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter logic [DATA_W-1:0] BUBBLE_INST = DATA_W'(RV32I_NOP)
) (
  input  logic              i_Clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_inst_data,
  input  logic [ADDR_W-1:0] i_inst_addr,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_inst_data,
  output logic [ADDR_W-1:0] o_inst_addr,
  output logic [1:0]        o_count
);

  skid_state_t       r_state;
  skid_state_t       w_state_next;
  logic [DATA_W-1:0] r_main_data;
  logic [ADDR_W-1:0] r_main_addr;
  logic [DATA_W-1:0] r_skid_data;
  logic [ADDR_W-1:0] r_skid_addr;
  logic              w_ready;
  logic              w_valid;
  logic              w_accept;
  logic              w_deliver;

  // o_ready comes from r_state alone, so no combinational path reaches it
  // from i_ready or i_valid.
  assign w_accept  = i_valid & w_ready;
  assign w_deliver = w_valid & i_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment at the top keeps this block from inferring
  // a latch on paths that leave the state unchanged.
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_next = ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_deliver) begin
            w_state_next = ST_TWO;
          end else if (w_deliver && !w_accept) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_TWO:   if (w_deliver) w_state_next = ST_ONE;
        default:  w_state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_ready     = (r_state != ST_TWO);
    w_valid     = (r_state != ST_EMPTY);
    o_ready     = w_ready;
    o_valid     = w_valid;
    o_count     = entry_count(r_state);
    o_inst_data = w_valid ? r_main_data : BUBBLE_INST;
    o_inst_addr = w_valid ? r_main_addr : '0;
  end

  // NOTE: the data registers are reset even though the outputs are masked
  // by o_valid, so the held contents are deterministic after reset.
  // A flush leaves them untouched; the state going to EMPTY is what discards entries.
  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      r_main_data <= BUBBLE_INST;
      r_main_addr <= '0;
      r_skid_data <= '0;
      r_skid_addr <= '0;
    end else if (!i_flush) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_data <= i_inst_data;
            r_main_addr <= i_inst_addr;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            r_main_data <= i_inst_data;
            r_main_addr <= i_inst_addr;
          end else if (w_accept) begin
            r_skid_data <= i_inst_data;
            r_skid_addr <= i_inst_addr;
          end
        end
        ST_TWO: begin
          if (w_deliver) begin
            r_main_data <= r_skid_data;
            r_main_addr <= r_skid_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus a randomized run, all
// compared against a two-deep FIFO queue model of the stage.
module tb_pipe_skid_stage;

  logic        i_Clk;
  logic        i_reset;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_inst_data;
  logic [31:0] i_inst_addr;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst_data;
  logic [31:0] o_inst_addr;
  logic [1:0]  o_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the stage is a FIFO of capacity two; the head is what ID sees.
  logic [63:0] q[$];

  pipe_skid_stage dut (
    .i_Clk      (i_Clk),
    .i_reset    (i_reset),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .i_inst_data(i_inst_data),
    .i_inst_addr(i_inst_addr),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_inst_data(o_inst_data),
    .o_inst_addr(o_inst_addr),
    .o_count    (o_count)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit acc;
    bit del;
    acc = i_valid && (q.size() < 2);
    del = (q.size() > 0) && i_ready;
    @(posedge i_Clk);
    if (i_reset || i_flush) begin
      q.delete();
    end else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back({i_inst_data, i_inst_addr});
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input logic [31:0] a);
    i_valid     = v;
    i_inst_data = d;
    i_inst_addr = a;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
    drive(1'b0, '0, '0);
    tick(); tick();
    i_reset = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 2'd0 ||
        o_inst_data !== 32'h0000_0013 || o_inst_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%b c=%0d d=%h a=%h, expected v=0 r=1 c=0 d=00000013 a=0",
               o_valid, o_ready, o_count, o_inst_data, o_inst_addr);
    end
  endtask

  task automatic test_single();
    i_ready = 1'b1;
    drive(1'b1, 32'h00A0_0093, 32'h0000_0004);
    tick();
    drive(1'b0, '0, '0);
    n_tests++;
    if (o_valid !== 1'b1 || o_inst_data !== 32'h00A0_0093 ||
        o_inst_addr !== 32'h4 || o_count !== 2'd1) begin
      n_fail++;
      $display("FAIL single: got v=%b d=%h a=%h c=%0d, expected v=1 d=00a00093 a=4 c=1",
               o_valid, o_inst_data, o_inst_addr, o_count);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b c=%0d, expected v=0 c=0", o_valid, o_count);
    end
  endtask

  task automatic test_stream();
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h0000_0100 + i, 32'h0000_1000 + 4 * i);
      tick();
      n_tests++;
      if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_count !== 2'd1 ||
          o_inst_data !== 32'h0000_0100 + i || o_inst_addr !== 32'h0000_1000 + 4 * i) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b r=%b c=%0d d=%h a=%h, expected v=1 r=1 c=1 d=%h a=%h",
                 i, o_valid, o_ready, o_count, o_inst_data, o_inst_addr,
                 32'h0000_0100 + i, 32'h0000_1000 + 4 * i);
      end
    end
    drive(1'b0, '0, '0);
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got v=%b, expected v=0", o_valid);
    end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    drive(1'b1, 32'h0010_0013, 32'h10); tick();
    drive(1'b1, 32'h0020_0093, 32'h14); tick();
    n_tests++;
    if (o_count !== 2'd2 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got c=%0d r=%b, expected c=2 r=0", o_count, o_ready);
    end
    drive(1'b1, 32'h0030_0033, 32'h18); tick();
    n_tests++;
    if (o_count !== 2'd2 || o_ready !== 1'b0 || o_inst_addr !== 32'h10 ||
        o_inst_data !== 32'h0010_0013) begin
      n_fail++;
      $display("FAIL bp_hold: got c=%0d r=%b d=%h a=%h, expected c=2 r=0 d=00100013 a=10",
               o_count, o_ready, o_inst_data, o_inst_addr);
    end
    drive(1'b0, '0, '0);
    i_ready = 1'b1;
    tick();
    n_tests++;
    if (o_valid !== 1'b1 || o_inst_addr !== 32'h14 || o_inst_data !== 32'h0020_0093 ||
        o_count !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_second: got v=%b c=%0d d=%h a=%h, expected v=1 c=1 d=00200093 a=14",
               o_valid, o_count, o_inst_data, o_inst_addr);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%b c=%0d, expected v=0 c=0 (third entry never accepted)",
               o_valid, o_count);
    end
  endtask

  task automatic test_flush_two();
    i_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 32'h20); tick();
    drive(1'b1, 32'hAAAA_0002, 32'h24); tick();
    drive(1'b0, '0, '0);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0 || o_count !== 2'd0 || o_ready !== 1'b1 ||
        o_inst_data !== 32'h0000_0013 || o_inst_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_two: got v=%b c=%0d r=%b d=%h a=%h, expected v=0 c=0 r=1 d=00000013 a=0",
               o_valid, o_count, o_ready, o_inst_data, o_inst_addr);
    end
  endtask

  task automatic test_flush_accept_one();
    i_ready = 1'b0;
    drive(1'b1, 32'hBBBB_0001, 32'h30); tick();
    drive(1'b1, 32'hBBBB_0002, 32'h34);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    drive(1'b0, '0, '0);
    n_tests++;
    if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_accept: got v=%b c=%0d, expected v=0 c=0", o_valid, o_count);
    end
    i_ready = 1'b1;
    tick();
    n_tests++;
    if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_accept_after: got v=%b c=%0d a=%h, expected v=0 c=0",
               o_valid, o_count, o_inst_addr);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    drive(1'b1, 32'hCCCC_0001, 32'h40); tick();
    drive(1'b1, 32'hCCCC_0002, 32'h44); tick();
    drive(1'b1, 32'hCCCC_0003, 32'h48);
    i_ready = 1'b1; i_reset = 1'b1; i_flush = 1'b1;
    tick();
    i_reset = 1'b0; i_flush = 1'b0;
    drive(1'b0, '0, '0);
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 2'd0 ||
        o_inst_data !== 32'h0000_0013 || o_inst_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b r=%b c=%0d d=%h a=%h, expected v=0 r=1 c=0 d=00000013 a=0",
               o_valid, o_ready, o_count, o_inst_data, o_inst_addr);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got v=%b a=%h, expected v=0", o_valid, o_inst_addr);
    end
  endtask

  task automatic test_random();
    logic        exp_valid;
    logic        exp_ready;
    logic [1:0]  exp_count;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom);
      i_ready = ($urandom_range(0, 9) < 6);
      i_flush = ($urandom_range(0, 29) == 0);
      i_reset = ($urandom_range(0, 99) == 0);
      tick();
      exp_valid = (q.size() > 0);
      exp_ready = (q.size() < 2);
      exp_count = 2'(q.size());
      exp_data  = exp_valid ? q[0][63:32] : 32'h0000_0013;
      exp_addr  = exp_valid ? q[0][31:0]  : 32'h0;
      n_tests++;
      if (o_valid !== exp_valid || o_ready !== exp_ready || o_count !== exp_count ||
          o_inst_data !== exp_data || o_inst_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b r=%b c=%0d d=%h a=%h, expected v=%b r=%b c=%0d d=%h a=%h",
                 i, o_valid, o_ready, o_count, o_inst_data, o_inst_addr,
                 exp_valid, exp_ready, exp_count, exp_data, exp_addr);
      end
    end
    i_reset = 1'b0; i_flush = 1'b0;
    drive(1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush_two();
    test_flush_accept_one();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 32, PC address width.
REQ-003 SHALL have parameter BUBBLE_INST, default 32'h00000013 (RV32I NOP), instruction driven when the output is not valid.
REQ-004 SHALL have port i_Clk, input, 1, clock, all state updates on the rising edge.
REQ-005 SHALL have port i_reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port i_flush, input, 1, discard all held entries (branch/jump redirect).
REQ-007 SHALL have port i_valid, input, 1, upstream (IF) entry present.
REQ-008 SHALL have port i_inst_data, input, DATA_W, upstream instruction.
REQ-009 SHALL have port i_inst_addr, input, ADDR_W, upstream PC.
REQ-010 SHALL have port o_ready, output, 1, stage can accept this cycle.
REQ-011 SHALL have port o_valid, output, 1, downstream (ID) entry present.
REQ-012 SHALL have port i_ready, input, 1, downstream accepts this cycle.
REQ-013 SHALL have port o_inst_data, output, DATA_W, held instruction.
REQ-014 SHALL have port o_inst_addr, output, ADDR_W, held PC.
REQ-015 SHALL have port o_count, output, 2, entries held (0..2).

Function
REQ-016 SHALL define accept = i_valid & o_ready and deliver = o_valid & i_ready.
REQ-017 SHALL hold up to two entries: a main register driving the outputs and a skid register.
REQ-018 SHALL use states EMPTY (0 entries), ONE (1), TWO (2); o_count equals the state's entry count.
REQ-019 SHALL assert o_ready iff state != TWO, decoded from state registers only (no combinational path from i_ready or i_valid).
REQ-020 SHALL assert o_valid iff state != EMPTY.
REQ-021 In EMPTY, accept SHALL load main and go to ONE.
REQ-022 In ONE, accept & deliver SHALL load main from input and stay ONE; accept & !deliver SHALL load skid and go to TWO; deliver & !accept SHALL go to EMPTY.
REQ-023 In TWO, deliver SHALL move skid to main and go to ONE; otherwise hold.
REQ-024 SHALL preserve entry order; no entry lost or duplicated absent flush.
REQ-025 SHALL present an accepted entry on the outputs one cycle after acceptance when the stage was EMPTY or delivering from ONE.
REQ-026 SHALL sustain one entry per cycle when i_valid and i_ready are held high.
REQ-027 i_flush SHALL force EMPTY on the next edge, discarding main, skid and any entry accepted in the same cycle.
REQ-028 When o_valid is low, o_inst_data SHALL equal BUBBLE_INST and o_inst_addr SHALL equal zero.
REQ-029 Held entries SHALL remain stable while o_valid & !i_ready.

Reset
REQ-030 i_reset SHALL take priority over i_flush and all handshakes.
REQ-031 After reset: state EMPTY, o_valid 0, o_ready 1, o_count 0, o_inst_data BUBBLE_INST, o_inst_addr 0, skid register 0.
REQ-032 Reset asserted mid-transfer SHALL drop all entries with no partial delivery.

Structure
REQ-033 The shared defines file SHALL hold the default widths, the NOP encoding and the state encoding.
REQ-034 SHALL be a single module with no sub-module; main and skid registers are inline.

Verification
REQ-035 Reset, then i_valid=1 with 0x00A00093/0x00000004, i_ready=1 -> o_valid=1 with that pair on the next cycle; o_count=1.
REQ-036 Stream of 8 entries with i_valid=i_ready=1 -> 8 entries delivered in order on consecutive cycles; o_ready never drops.
REQ-037 Hold i_ready=0 and push 0x...13/0x10, 0x...93/0x14, 0x...33/0x18 -> third not accepted, o_ready=0, o_count=2; raise i_ready -> outputs 0x10 then 0x14 in order.
REQ-038 With o_count=2, assert i_flush for one cycle -> next cycle o_valid=0, o_count=0, o_inst_data=0x00000013, o_inst_addr=0.
REQ-039 Flush coincident with accept in ONE -> accepted entry is discarded; stage is EMPTY next cycle.
REQ-040 Assert i_reset while in TWO with i_ready=1 -> no delivery after the reset edge; all reset values per REQ-031.
